// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage: lane selection, load extension, and
// read-modify-write of sub-word stores through a two-state merge FSM.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  LoadUnsigned,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWriteEn,
    output logic                  MemReadEn,
    input  logic [DATA_WIDTH-1:0] MemReadData,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  Stall,
    output logic                  AddrError
);

    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        MERGE_WRITE = 1'b1
    } lsuState_t;

    lsuState_t        stateR;
    lsuState_t        nextStateS;
    logic [31:0]      addrR;
    logic [31:0]      mergedR;
    logic             addrErrorR;
    logic             misalignedS;
    logic             captureS;
    logic [31:0]      alignedAddrS;

    // Replace the addressed byte/half lane of a memory word with store data.
    function automatic logic [31:0] mergeLane(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        if (size == 2'b00) begin
            case (lane)
                2'b00:   res[7:0]   = data[7:0];
                2'b01:   res[15:8]  = data[7:0];
                2'b10:   res[23:16] = data[7:0];
                2'b11:   res[31:24] = data[7:0];
                default: res        = word;
            endcase
        end else if (size == 2'b01) begin
            if (lane[1]) begin
                res[31:16] = data[15:0];
            end else begin
                res[15:0] = data[15:0];
            end
        end else begin
            res = data;
        end
        return res;
    endfunction

    // Pull the addressed lane out of a memory word and sign/zero-extend it.
    function automatic logic [31:0] extractLane(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign alignedAddrS = {Address[31:2], 2'b00};
    assign misalignedS  = (MemRead | MemWrite) &
                          (((Size == 2'b01) & Address[0]) |
                           ((Size == 2'b10) & (Address[1:0] != 2'b00)) |
                           (Size == 2'b11));
    assign AddrError    = addrErrorR;

    // Next-state and combinational memory-side outputs.
    always_comb begin
        nextStateS   = stateR;
        MemAddress   = alignedAddrS;
        MemWriteData = WriteData;
        MemWriteEn   = 1'b0;
        MemReadEn    = 1'b0;
        LoadData     = 32'h0000_0000;
        Stall        = 1'b0;
        captureS     = 1'b0;
        case (stateR)
            IDLE: begin
                if (misalignedS) begin
                    nextStateS = IDLE;
                end else if (MemWrite) begin
                    if (Size == 2'b10) begin
                        MemWriteEn = 1'b1;
                    end else begin
                        MemReadEn  = 1'b1;
                        Stall      = 1'b1;
                        captureS   = 1'b1;
                        nextStateS = MERGE_WRITE;
                    end
                end else if (MemRead) begin
                    MemReadEn = 1'b1;
                    LoadData  = extractLane(MemReadData, Size, Address[1:0], LoadUnsigned);
                end else begin
                    nextStateS = IDLE;
                end
            end
            MERGE_WRITE: begin
                // Write strobe depends only on state so reset kills it at once.
                MemAddress   = addrR;
                MemWriteData = mergedR;
                MemWriteEn   = 1'b1;
                nextStateS   = IDLE;
            end
            default: begin
                nextStateS = IDLE;
            end
        endcase
    end

    // State, merge capture registers and the one-cycle error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR     <= IDLE;
            addrR      <= 32'h0000_0000;
            mergedR    <= 32'h0000_0000;
            addrErrorR <= 1'b0;
        end else begin
            stateR     <= nextStateS;
            addrErrorR <= misalignedS & (stateR == IDLE);
            if (captureS) begin
                addrR   <= alignedAddrS;
                mergedR <= mergeLane(MemReadData, WriteData, Size, Address[1:0]);
            end else begin
                addrR   <= addrR;
                mergedR <= mergedR;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed vectors.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        LoadUnsigned;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEn;
    logic        MemReadEn;
    logic [31:0] MemReadData;
    logic [31:0] LoadData;
    logic        Stall;
    logic        AddrError;

    int checkCount;
    int errorCount;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Size         (Size),
        .LoadUnsigned (LoadUnsigned),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWriteEn   (MemWriteEn),
        .MemReadEn    (MemReadEn),
        .MemReadData  (MemReadData),
        .LoadData     (LoadData),
        .Stall        (Stall),
        .AddrError    (AddrError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        MemRead      = rd;
        MemWrite     = wr;
        Size         = sz;
        LoadUnsigned = uns;
        Address      = addr;
        WriteData    = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b1;
        MemReadData = 32'h0000_0000;
        idle();
        #12;
        checkEq("rst_wen",   {31'd0, MemWriteEn}, 32'd0);
        checkEq("rst_ren",   {31'd0, MemReadEn},  32'd0);
        checkEq("rst_stall", {31'd0, Stall},      32'd0);
        checkEq("rst_aerr",  {31'd0, AddrError},  32'd0);
        checkEq("rst_ld",    LoadData,            32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        nextCycle();

        // Word store: single cycle
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
        #1;
        checkEq("sw_wen",   {31'd0, MemWriteEn}, 32'd1);
        checkEq("sw_addr",  MemAddress,          32'h1001_0004);
        checkEq("sw_wdata", MemWriteData,        32'hDEAD_BEEF);
        checkEq("sw_stall", {31'd0, Stall},      32'd0);
        nextCycle();
        idle();
        #1;
        checkEq("sw_done_wen", {31'd0, MemWriteEn}, 32'd0);

        // Byte store: read phase then merged write, inputs ignored in merge
        MemReadData = 32'h1122_3344;
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0001, 32'h0000_00AA);
        #1;
        checkEq("sb_c1_stall", {31'd0, Stall},      32'd1);
        checkEq("sb_c1_ren",   {31'd0, MemReadEn},  32'd1);
        checkEq("sb_c1_wen",   {31'd0, MemWriteEn}, 32'd0);
        checkEq("sb_c1_addr",  MemAddress,          32'h1001_0000);
        nextCycle();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h2000_0000, 32'h5555_5555);
        MemReadData = 32'hFFFF_FFFF;
        #1;
        checkEq("sb_c2_wen",   {31'd0, MemWriteEn}, 32'd1);
        checkEq("sb_c2_wdata", MemWriteData,        32'h1122_AA44);
        checkEq("sb_c2_addr",  MemAddress,          32'h1001_0000);
        checkEq("sb_c2_stall", {31'd0, Stall},      32'd0);
        checkEq("sb_c2_ren",   {31'd0, MemReadEn},  32'd0);
        checkEq("sb_c2_ld",    LoadData,            32'h0000_0000);
        idle();
        nextCycle();
        checkEq("sb_c3_wen",   {31'd0, MemWriteEn}, 32'd0);

        // Half store to upper lane
        MemReadData = 32'h1122_3344;
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_BEEF);
        #1;
        checkEq("sh_c1_stall", {31'd0, Stall}, 32'd1);
        nextCycle();
        idle();
        #1;
        checkEq("sh_c2_wen",   {31'd0, MemWriteEn}, 32'd1);
        checkEq("sh_c2_wdata", MemWriteData,        32'hBEEF_3344);
        checkEq("sh_c2_addr",  MemAddress,          32'h1001_0000);
        nextCycle();

        // Loads with sign/zero extension
        MemReadData = 32'h80FF_0000;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'h0);
        #1;
        checkEq("lb",     LoadData,           32'hFFFF_FF80);
        checkEq("lb_ren", {31'd0, MemReadEn}, 32'd1);
        checkEq("lb_stl", {31'd0, Stall},     32'd0);
        LoadUnsigned = 1'b1;
        #1;
        checkEq("lbu", LoadData, 32'h0000_0080);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h1001_0002, 32'h0);
        #1;
        checkEq("lh",  LoadData, 32'hFFFF_80FF);
        LoadUnsigned = 1'b1;
        #1;
        checkEq("lhu", LoadData, 32'h0000_80FF);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h1001_0000, 32'h0);
        #1;
        checkEq("lh_lo", LoadData, 32'h0000_0000);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0002, 32'h0);
        #1;
        checkEq("lb_2", LoadData, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0);
        #1;
        checkEq("lw", LoadData, 32'h80FF_0000);

        // Read and write together behave as a store
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h0BAD_F00D);
        #1;
        checkEq("rw_ld",  LoadData,            32'h0000_0000);
        checkEq("rw_wen", {31'd0, MemWriteEn}, 32'd1);
        nextCycle();

        // Misaligned half store
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h0000_1234);
        #1;
        checkEq("mis_sh_wen",  {31'd0, MemWriteEn}, 32'd0);
        checkEq("mis_sh_ren",  {31'd0, MemReadEn},  32'd0);
        checkEq("mis_sh_stl",  {31'd0, Stall},      32'd0);
        checkEq("mis_sh_aerr0", {31'd0, AddrError}, 32'd0);
        nextCycle();
        idle();
        #1;
        checkEq("mis_sh_aerr1", {31'd0, AddrError}, 32'd1);
        checkEq("mis_sh_nomerge", {31'd0, MemWriteEn}, 32'd0);
        nextCycle();
        checkEq("mis_sh_aerr2", {31'd0, AddrError}, 32'd0);

        // Misaligned word load
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0);
        #1;
        checkEq("mis_lw_ld",  LoadData,            32'h0000_0000);
        checkEq("mis_lw_ren", {31'd0, MemReadEn},  32'd0);
        nextCycle();
        idle();
        #1;
        checkEq("mis_lw_aerr1", {31'd0, AddrError}, 32'd1);
        nextCycle();
        checkEq("mis_lw_aerr2", {31'd0, AddrError}, 32'd0);

        // Reserved size
        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0);
        #1;
        checkEq("rsv_ld", LoadData, 32'h0000_0000);
        nextCycle();
        idle();
        #1;
        checkEq("rsv_aerr", {31'd0, AddrError}, 32'd1);
        nextCycle();

        // Reset during merge aborts the write
        MemReadData = 32'h1122_3344;
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0001, 32'h0000_00AA);
        nextCycle();
        idle();
        #1;
        checkEq("rm_pre_wen", {31'd0, MemWriteEn}, 32'd1);
        reset = 1'b1;
        #1;
        checkEq("rm_wen",  {31'd0, MemWriteEn}, 32'd0);
        checkEq("rm_addr", MemAddress,          32'h0000_0000);
        #1;
        reset = 1'b0;
        nextCycle();
        checkEq("rm_after_wen", {31'd0, MemWriteEn}, 32'd0);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_000C, 32'hCAFE_F00D);
        #1;
        checkEq("rm_sw_wen",   {31'd0, MemWriteEn}, 32'd1);
        checkEq("rm_sw_wdata", MemWriteData,        32'hCAFE_F00D);
        checkEq("rm_sw_addr",  MemAddress,          32'h1001_000C);
        nextCycle();
        idle();
        #1;
        checkEq("rm_sw_done", {31'd0, MemWriteEn}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
